pmem_responder: RTL and testbench

Line-granular physical-memory responder; the memory-side end of the cache's `pmem` interface. It accepts one 128-bit line read or write per transaction on a 12-bit line address. It returns a single-cycle `pmem_resp` after a fixed, parameterised latency. It is the memory behind the cache datapath/control pair in simulation and FPGA builds, and must be synthesizable.

---
 rtl/pmem_responder.sv | 160 ++++++++++++++++
 tb/tb_pmem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Line-granular memory responder: one 128-bit line read/write per request, single-cycle
// pmem_resp after LATENCY cycles. Optional protocol checker enabled by PMEM_PROTOCOL_CHECK_EN.
module pmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [127:0]          pmem_wdata,
  output logic [127:0]          pmem_rdata,
  output logic                  pmem_resp,
  output logic                  pmem_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  logic [127:0]          mem_q [2**ADDR_WIDTH];
  logic [127:0]          rd_line_q;
  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [127:0]          rdata_q, rdata_d;
  logic                  resp_q, resp_d;
  logic                  accept_s;

  // rst_n gating keeps a request held during reset from touching storage
  assign accept_s = rst_n && (state_q == IDLE) && (pmem_read || pmem_write);

  // Storage port: writes commit at acceptance, reads snapshot the line at acceptance
  always_ff @(posedge clk) begin
    if (accept_s && pmem_write) begin
      mem_q[pmem_address] <= pmem_wdata;
    end else if (accept_s) begin
      rd_line_q <= mem_q[pmem_address];
    end
  end

  // Next-state, counter and output register computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_write_d = pmem_write;
          addr_d     = pmem_address;
          cnt_d      = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = RESP;
            // no BUSY cycle to move the snapshot, so read storage directly
            if (!pmem_write) begin
              rdata_d = mem_q[pmem_address];
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = RESP;
          if (!op_write_q) begin
            rdata_d = rd_line_q;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = BUSY;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    resp_d = (state_d == RESP);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      rdata_q    <= 128'd0;
      resp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic         err_q, err_d;
  logic         viol_s;
  logic [127:0] wdata_q, wdata_d;

  // Protocol violation detection; the flag is sticky until reset
  always_comb begin
    viol_s  = 1'b0;
    wdata_d = wdata_q;
    if (accept_s) begin
      wdata_d = pmem_wdata;
      viol_s  = pmem_read && pmem_write;
    end else if (state_q == BUSY) begin
      viol_s = (pmem_address != addr_q) ||
               (op_write_q && (pmem_wdata != wdata_q)) ||
               (op_write_q ? !pmem_write : !pmem_read);
    end else begin
      viol_s = 1'b0;
    end
    err_d = err_q | viol_s;
  end

  // Checker state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      wdata_q <= 128'd0;
    end else begin
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

`ifndef SYNTHESIS
  // Report the first violation after each reset
  always_ff @(posedge clk) begin
    if (rst_n && viol_s && !err_q) begin
      $error("pmem_responder: protocol violation in state %0d", state_q);
    end
  end
`endif

  assign pmem_err = err_q;
`else
  assign pmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: LATENCY=10 main instance plus a LATENCY=1
// instance for back-to-back timing.
module tb_pmem_responder;

  localparam int LAT = 10;
`ifdef PMEM_PROTOCOL_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D0 = 128'hA5A5A5A5_11111111_22222222_33333333;
  localparam logic [127:0] DF = 128'h5A5A5A5A_44444444_55555555_66666666;
  localparam logic [127:0] D3 = 128'hCAFEF00D_DEADBEEF_0BADC0DE_12345678;
  localparam logic [127:0] D4 = 128'h00000000_FFFFFFFF_00000000_FFFFFFFF;
  localparam logic [127:0] D5 = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd, wr;
  logic [11:0]  addr;
  logic [127:0] wdata, rdata;
  logic         resp, err;
  logic         rd1, wr1;
  logic [11:0]  addr1;
  logic [127:0] wdata1, rdata1;
  logic         resp1, err1;

  always #5 clk = ~clk;

  pmem_responder #(.ADDR_WIDTH(12), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd), .pmem_write(wr), .pmem_address(addr),
    .pmem_wdata(wdata), .pmem_rdata(rdata), .pmem_resp(resp), .pmem_err(err)
  );

  pmem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd1), .pmem_write(wr1), .pmem_address(addr1),
    .pmem_wdata(wdata1), .pmem_rdata(rdata1), .pmem_resp(resp1), .pmem_err(err1)
  );

  typedef struct {
    logic         is_read;
    logic [127:0] data;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] model [int];
  int           checks = 0;
  int           errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for resp after the acceptance edge; returns cycle index of resp
  task automatic wait_resp(output int n);
    @(posedge clk);
    #1;
    n = 1;
    while (!resp && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input logic is_wr, input logic [11:0] a, input logic [127:0] d,
                       input string tag);
    exp_t e;
    int   n;
    @(negedge clk);
    wr = is_wr; rd = !is_wr; addr = a; wdata = d;
    e.is_read = !is_wr;
    e.data    = is_wr ? 128'd0 : model[int'(a)];
    sb_q.push_back(e);
    if (is_wr) model[int'(a)] = d;
    wait_resp(n);
    check_eq($sformatf("%s_lat", tag), 128'(n), 128'(LAT));
    e = sb_q.pop_front();
    if (e.is_read) check_eq($sformatf("%s_data", tag), rdata, e.data);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int   n;
    logic seen;
    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = 12'd0; wdata = 128'd0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 12'd0; wdata1 = 128'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_resp", 128'(resp), 128'd0);
    check_eq("rst_rdata", rdata, 128'd0);
    check_eq("rst_err", 128'(err), 128'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      seen = seen | resp;
    end
    check_eq("idle_no_resp", 128'(seen), 128'd0);

    // Main function and address extremes
    do_op(1'b1, 12'h005, D1, "wr005");
    do_op(1'b0, 12'h005, D1, "rd005");
    do_op(1'b1, 12'h000, D0, "wr000");
    check_eq("rdata_hold_wr", rdata, D1);
    do_op(1'b1, 12'hFFF, DF, "wrFFF");
    do_op(1'b0, 12'h000, D0, "rd000");
    do_op(1'b0, 12'hFFF, DF, "rdFFF");

    // LATENCY=1 back-to-back: write, then read held through two transactions
    @(negedge clk);
    wr1 = 1'b1; addr1 = 12'h010; wdata1 = D3;
    @(posedge clk);
    #1;
    check_eq("l1_resp_c1", 128'(resp1), 128'd1);
    @(negedge clk);
    wr1 = 1'b0; rd1 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("l1_gap_c2", 128'(resp1), 128'd0);
    @(posedge clk);
    #1;
    check_eq("l1_resp_c3", 128'(resp1), 128'd1);
    check_eq("l1_data_c3", rdata1, D3);
    @(posedge clk);
    #1;
    check_eq("l1_gap_c4", 128'(resp1), 128'd0);
    @(posedge clk);
    #1;
    check_eq("l1_resp_c5", 128'(resp1), 128'd1);
    @(negedge clk);
    rd1 = 1'b0;

    // Reset during BUSY of a read
    @(negedge clk);
    rd = 1'b1; addr = 12'h005;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; rd = 1'b0;
    #1;
    check_eq("midrst_resp", 128'(resp), 128'd0);
    check_eq("midrst_rdata", rdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      seen = seen | resp;
    end
    check_eq("midrst_no_resp", 128'(seen), 128'd0);
    do_op(1'b0, 12'h005, D1, "rd005_postrst");

    // Reset during BUSY of a write: the write stays committed
    @(negedge clk);
    wr = 1'b1; addr = 12'h0AA; wdata = D5;
    model[int'(12'h0AA)] = D5;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 12'h0AA, D5, "rd0AA_postrst");

    // Simultaneous read and write: write wins, no read data, err per build
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = 12'h020; wdata = D4;
    model[int'(12'h020)] = D4;
    wait_resp(n);
    check_eq("both_lat", 128'(n), 128'(LAT));
    check_eq("both_rdata_hold", rdata, D5);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("both_err", 128'(err), 128'(ERR_EN));
    do_op(1'b0, 12'h020, D4, "rd020");
    check_eq("both_err_sticky", 128'(err), 128'(ERR_EN));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("err_cleared", 128'(err), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
